// File: rtl/mac_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mac_seq_ctrl_if : command, operand-buffer, MAC and result signals of mac_seq_ctrl
// Rev 1.0
// ============================================================================
interface mac_seq_ctrl_if #(
    parameter int W_BITWIDTH   = 8,
    parameter int IN_BITWIDTH  = 8,
    parameter int OUT_BITWIDTH = 32,
    parameter int ADDR_W       = 8
);
    logic                      start;
    logic [ADDR_W-1:0]         base_addr;
    logic [ADDR_W-1:0]         num_groups;
    logic [OUT_BITWIDTH-1:0]   bias;
    logic                      busy;

    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic [3*W_BITWIDTH-1:0]   rd_w;
    logic [3*IN_BITWIDTH-1:0]  rd_x;

    logic                      mac_en;
    logic [W_BITWIDTH-1:0]     mac_w0;
    logic [W_BITWIDTH-1:0]     mac_w1;
    logic [W_BITWIDTH-1:0]     mac_w2;
    logic [IN_BITWIDTH-1:0]    mac_x0;
    logic [IN_BITWIDTH-1:0]    mac_x1;
    logic [IN_BITWIDTH-1:0]    mac_x2;
    logic [OUT_BITWIDTH-1:0]   mac_pre_sum;
    logic                      mac_done;
    logic [OUT_BITWIDTH-1:0]   mac_out;

    logic                      res_valid;
    logic                      res_ready;
    logic [OUT_BITWIDTH-1:0]   res_data;
    logic                      res_err;

    modport master (
        input  start, base_addr, num_groups, bias,
        input  rd_w, rd_x, mac_done, mac_out, res_ready,
        output busy, rd_en, rd_addr, mac_en,
        output mac_w0, mac_w1, mac_w2, mac_x0, mac_x1, mac_x2, mac_pre_sum,
        output res_valid, res_data, res_err
    );

    modport slave (
        output start, base_addr, num_groups, bias,
        output rd_w, rd_x, mac_done, mac_out, res_ready,
        input  busy, rd_en, rd_addr, mac_en,
        input  mac_w0, mac_w1, mac_w2, mac_x0, mac_x1, mac_x2, mac_pre_sum,
        input  res_valid, res_data, res_err
    );
endinterface
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mac_seq_ctrl : chains 3-lane MAC groups from an operand buffer into one dot product
// Rev 1.0
// ============================================================================
module mac_seq_ctrl #(
    parameter int W_BITWIDTH   = 8,
    parameter int IN_BITWIDTH  = 8,
    parameter int OUT_BITWIDTH = 32,
    parameter int ADDR_W       = 8,
    parameter int RESULT_DELAY = 1,
    parameter int TIMEOUT      = 64
) (
    input  logic           clk,
    input  logic           rstn,
    mac_seq_ctrl_if.master bus
);
    localparam int C_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int C_SET_W    = (RESULT_DELAY > 1) ? $clog2(RESULT_DELAY) : 1;
    localparam int C_SET_LAST = (RESULT_DELAY > 1) ? RESULT_DELAY - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_WAIT   = 3'd3,
        S_SETTLE = 3'd4,
        S_GUARD  = 3'd5,
        S_RESULT = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [ADDR_W-1:0]        num_q, num_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [OUT_BITWIDTH-1:0]  acc_q, acc_d;
    logic [3*W_BITWIDTH-1:0]  w_q, w_d;
    logic [3*IN_BITWIDTH-1:0] x_q, x_d;
    logic [C_TMO_W-1:0]       tmo_q, tmo_d;
    logic [C_SET_W-1:0]       set_q, set_d;
    logic                     mac_en_q, mac_en_d;
    logic                     busy_q, busy_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            num_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            w_q      <= '0;
            x_q      <= '0;
            tmo_q    <= '0;
            set_q    <= '0;
            mac_en_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            num_q    <= num_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            w_q      <= w_d;
            x_q      <= x_d;
            tmo_q    <= tmo_d;
            set_q    <= set_d;
            mac_en_q <= mac_en_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        num_d    = num_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        w_d      = w_q;
        x_d      = x_q;
        tmo_d    = tmo_q;
        set_d    = set_q;
        mac_en_d = 1'b0;
        busy_d   = busy_q;
        valid_d  = valid_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d = bus.base_addr;
                    num_d  = bus.num_groups;
                    idx_d  = '0;
                    acc_d  = bus.bias;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (bus.num_groups == '0) begin
                        state_d = S_RESULT;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                // Buffer data is valid now; mac_en rises together with the registered lanes.
                w_d      = bus.rd_w;
                x_d      = bus.rd_x;
                mac_en_d = 1'b1;
                tmo_d    = '0;
                set_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mac_done) begin
                    state_d = S_SETTLE;
                end else if (tmo_q == C_TMO_W'(TIMEOUT - 1)) begin
                    state_d = S_RESULT;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + C_TMO_W'(1);
                end
            end
            S_SETTLE: begin
                if (set_q == C_SET_W'(C_SET_LAST)) begin
                    acc_d   = bus.mac_out;
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_GUARD;
                end else begin
                    set_d = set_q + C_SET_W'(1);
                end
            end
            S_GUARD: begin
                if (idx_q == num_q) begin
                    state_d = S_RESULT;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_RESULT: begin
                if (valid_q && bus.res_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.rd_en       = (state_q == S_FETCH);
    assign bus.rd_addr     = base_q + idx_q;
    assign bus.mac_en      = mac_en_q;
    assign bus.mac_w0      = w_q[W_BITWIDTH-1:0];
    assign bus.mac_w1      = w_q[2*W_BITWIDTH-1:W_BITWIDTH];
    assign bus.mac_w2      = w_q[3*W_BITWIDTH-1:2*W_BITWIDTH];
    assign bus.mac_x0      = x_q[IN_BITWIDTH-1:0];
    assign bus.mac_x1      = x_q[2*IN_BITWIDTH-1:IN_BITWIDTH];
    assign bus.mac_x2      = x_q[3*IN_BITWIDTH-1:2*IN_BITWIDTH];
    // The accumulator only moves at the end of SETTLE, so it doubles as the stable pre_sum.
    assign bus.mac_pre_sum = acc_q;
    assign bus.res_valid   = valid_q;
    assign bus.res_data    = acc_q;
    assign bus.res_err     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for mac_seq_ctrl: operand buffer and MAC models, scoreboard of results and per-group traffic.
module tb_mac_seq_ctrl;
    localparam int W   = 8;
    localparam int XB  = 8;
    localparam int OW  = 32;
    localparam int AW  = 8;
    localparam int RD  = 1;
    localparam int TMO = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.W_BITWIDTH(W), .IN_BITWIDTH(XB), .OUT_BITWIDTH(OW), .ADDR_W(AW)) bus ();

    mac_seq_ctrl #(
        .W_BITWIDTH(W), .IN_BITWIDTH(XB), .OUT_BITWIDTH(OW), .ADDR_W(AW),
        .RESULT_DELAY(RD), .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct { logic [31:0] data; logic err; int nmac; } res_t;
    typedef struct { logic [31:0] pre; logic [23:0] w; logic [23:0] x; } grp_t;

    res_t        exp_q [$];
    grp_t        grp_q [$];
    logic [7:0]  addr_q[$];
    logic [23:0] mem_w [256];
    logic [23:0] mem_x [256];
    int          n_pass  = 0;
    int          n_total = 0;
    bit          mac_hang = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: got an unexpected event, required none", name);
    endtask

    function automatic logic [31:0] dot3(input logic [23:0] w, input logic [23:0] x);
        int s;
        s = 0;
        for (int k = 0; k < 3; k++)
            s += int'($signed(w[8*k +: 8])) * int'($signed(x[8*k +: 8]));
        return 32'(s);
    endfunction

    function automatic logic any_out();
        return |{bus.busy, bus.rd_en, bus.rd_addr, bus.mac_en, bus.mac_w0, bus.mac_w1, bus.mac_w2,
                 bus.mac_x0, bus.mac_x1, bus.mac_x2, bus.mac_pre_sum, bus.res_valid, bus.res_data,
                 bus.res_err};
    endfunction

    // Synchronous-read operand buffer; garbage outside the valid cycle exposes timing slips.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.rd_w <= '0;
            bus.rd_x <= '0;
        end else if (bus.rd_en) begin
            bus.rd_w <= mem_w[bus.rd_addr];
            bus.rd_x <= mem_x[bus.rd_addr];
        end else begin
            bus.rd_w <= 24'($urandom);
            bus.rd_x <= 24'($urandom);
        end
    end

    // MAC: random latency, mac_out garbage on the done cycle and valid RESULT_DELAY later.
    logic [31:0] mac_res;
    int          mac_left;
    bit          mac_pend, mac_fin;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.mac_done <= 1'b0;
            bus.mac_out  <= '0;
            mac_res      <= '0;
            mac_left     <= 0;
            mac_pend     <= 1'b0;
            mac_fin      <= 1'b0;
        end else begin
            bus.mac_done <= 1'b0;
            mac_fin      <= 1'b0;
            if (mac_fin) bus.mac_out <= mac_res;
            if (bus.mac_en) begin
                mac_res  <= bus.mac_pre_sum + dot3({bus.mac_w2, bus.mac_w1, bus.mac_w0},
                                                   {bus.mac_x2, bus.mac_x1, bus.mac_x0});
                mac_left <= int'($urandom_range(1, 4));
                mac_pend <= !mac_hang;
            end else if (mac_pend) begin
                if (mac_left <= 1) begin
                    bus.mac_done <= 1'b1;
                    bus.mac_out  <= 32'hDEAD_BEEF;
                    mac_pend     <= 1'b0;
                    mac_fin      <= 1'b1;
                end else begin
                    mac_left <= mac_left - 1;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT fetches, starts the MAC or hands over a result.
    int   mac_seen = 0;
    int   rd_seen  = 0;
    grp_t mg;
    res_t mr;
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mac_seen = 0;
                rd_seen  = 0;
            end else begin
                if (bus.rd_en) begin
                    rd_seen++;
                    if (addr_q.size() == 0) fail("rd_unexpected");
                    else chk("rd_addr", 64'(bus.rd_addr), 64'(addr_q.pop_front()));
                end
                if (bus.mac_en) begin
                    mac_seen++;
                    if (grp_q.size() == 0) fail("mac_unexpected");
                    else begin
                        mg = grp_q.pop_front();
                        chk("mac_pre_sum", 64'(bus.mac_pre_sum), 64'(mg.pre));
                        chk("mac_lanes",
                            64'({bus.mac_w2, bus.mac_w1, bus.mac_w0, bus.mac_x2, bus.mac_x1, bus.mac_x0}),
                            64'({mg.w, mg.x}));
                    end
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) fail("res_unexpected");
                    else begin
                        mr = exp_q.pop_front();
                        chk("res_data", 64'(bus.res_data), 64'(mr.data));
                        chk("res_err", 64'(bus.res_err), 64'(mr.err));
                        chk("mac_en_count", 64'(mac_seen), 64'(mr.nmac));
                        chk("rd_en_count", 64'(rd_seen), 64'(mr.nmac));
                    end
                    mac_seen = 0;
                    rd_seen  = 0;
                end
            end
        end
    end

    task automatic set_grp(input logic [7:0] a, input int w0, input int w1, input int w2,
                           input int x0, input int x1, input int x2);
        mem_w[a] = {8'(w2), 8'(w1), 8'(w0)};
        mem_x[a] = {8'(x2), 8'(x1), 8'(x0)};
    endtask

    // Reference: bias plus the signed dot product of every group, 32-bit wrap.
    task automatic issue(input logic [7:0] base, input logic [7:0] n, input logic [31:0] bias,
                         input bit hang);
        logic [31:0] acc;
        logic [7:0]  a;
        int          fed;
        acc = bias;
        fed = 0;
        for (int g = 0; g < int'(n); g++) begin
            a = base + 8'(g);
            addr_q.push_back(a);
            grp_q.push_back('{acc, mem_w[a], mem_x[a]});
            fed++;
            if (hang) break;
            acc = acc + dot3(mem_w[a], mem_x[a]);
        end
        exp_q.push_back('{acc, hang && (n != 0), fed});
        mac_hang       = hang;
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.num_groups = n;
        bus.bias       = bias;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.base_addr  = 8'($urandom);
        bus.num_groups = 8'($urandom);
        bus.bias       = $urandom;
    endtask

    task automatic wait_done(input int maxc, input bit rnd);
        int c;
        c = 0;
        while (bus.busy && c < maxc) begin
            bus.res_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk); #1;
            c++;
        end
        bus.res_ready = 1'b0;
        chk("cmd_complete", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int nm;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_groups = '0; bus.bias = '0; bus.res_ready = 1'b0;
        for (int a = 0; a < 256; a++) begin
            mem_w[a] = 24'($urandom);
            mem_x[a] = 24'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(any_out()), 64'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Single group: 1*4 + 2*5 + 3*6 + 10 = 42
        set_grp(8'd5, 1, 2, 3, 4, 5, 6);
        issue(8'd5, 8'd1, 32'd10, 1'b0);
        wait_done(200, 1'b0);

        // Two groups with negatives: -15 then -270
        set_grp(8'd20, -2, 3, 1, 5, -4, 7);
        set_grp(8'd21, 127, -128, 0, -1, 1, 9);
        issue(8'd20, 8'd2, 32'd0, 1'b0);
        wait_done(200, 1'b1);

        // Zero groups: result straight from bias one cycle after start
        issue(8'd77, 8'd0, -32'sd7, 1'b0);
        chk("zero_grp_valid", 64'(bus.res_valid), 64'd1);
        wait_done(20, 1'b0);

        // Backpressure with ignored start pulses
        issue(8'd40, 8'd1, $urandom, 1'b0);
        cnt = 0;
        while (!bus.res_valid && cnt < 200) begin @(posedge clk); #1; cnt++; end
        chk("bp_valid_seen", 64'(bus.res_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            bus.start      = 1'b1;
            bus.base_addr  = 8'($urandom);
            bus.num_groups = 8'($urandom_range(1, 255));
            bus.bias       = $urandom;
            @(posedge clk); #1;
            chk("bp_valid_hold", 64'(bus.res_valid), 64'd1);
            chk("bp_data_hold", 64'(bus.res_data), 64'(exp_q[0].data));
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("bp_busy_drop", 64'(bus.busy), 64'd0);
        chk("bp_valid_drop", 64'(bus.res_valid), 64'd0);
        @(posedge clk); #1;
        chk("bp_stay_idle", 64'(bus.busy), 64'd0);

        // Timeout: FETCH + LOAD + TIMEOUT WAIT cycles before the result appears
        issue(8'($urandom), 8'd2, $urandom, 1'b1);
        chk("tmo_fetch", 64'(bus.rd_en), 64'd1);
        cnt = 0;
        while (!bus.res_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
        chk("tmo_latency", 64'(cnt), 64'(2 + TMO));
        wait_done(20, 1'b0);
        issue(8'($urandom), 8'd2, $urandom, 1'b0);
        wait_done(300, 1'b1);

        // Reset during WAIT of group 2 of 3
        issue(8'd100, 8'd3, $urandom, 1'b0);
        cnt = 0;
        nm  = 0;
        while (nm < 2 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.mac_en) nm++;
        end
        chk("rst_reached_g2", 64'(nm), 64'd2);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_outputs", 64'(any_out()), 64'd0);
        exp_q.delete();
        grp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        issue(8'($urandom), 8'd1, $urandom, 1'b0);
        wait_done(200, 1'b1);
        issue(8'd255, 8'd2, $urandom, 1'b0);
        wait_done(200, 1'b1);

        // Randomized commands
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 8; k++) begin
                mem_w[8'($urandom)] = 24'($urandom);
                mem_x[8'($urandom)] = 24'($urandom);
            end
            issue(8'($urandom), 8'($urandom_range(0, 5)), $urandom, 1'b0);
            wait_done(400, 1'b1);
        end

        @(posedge clk); #1;
        chk("scoreboard_drained", 64'(exp_q.size() + grp_q.size() + addr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
